// File: rtl/ssid_event_feeder_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ssid_event_feeder_pkg : shared width, state encoding, helpers   (rev 1.0)
// -----------------------------------------------------------------------------
package ssid_event_feeder_pkg;

  localparam int SSIDBITS = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    READ   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssid_event_feeder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ssid_event_feeder_if : front-end and storage-side bundle          (rev 1.0)
// -----------------------------------------------------------------------------
interface ssid_event_feeder_if
  import ssid_event_feeder_pkg::*;
  ();

  logic [SSIDBITS-1:0] inSSID;
  logic                inValid;
  logic                inLast;
  logic                inReady;
  logic                storageReady;
  logic                readReady;
  logic [SSIDBITS-1:0] SSID;
  logic                newAddress;
  logic                clearMemory;
  logic                readMemory;
  logic                eventDone;
  logic [15:0]         ssidCount;

  modport slave (
    input  inSSID, inValid, inLast, storageReady, readReady,
    output inReady, SSID, newAddress, clearMemory, readMemory, eventDone, ssidCount
  );

  modport master (
    output inSSID, inValid, inLast, storageReady, readReady,
    input  inReady, SSID, newAddress, clearMemory, readMemory, eventDone, ssidCount
  );

endinterface
`default_nettype wire

// File: rtl/ssid_sync_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ssid_sync_fifo : single-clock FIFO with wrap-bit pointers          (rev 1.0)
// -----------------------------------------------------------------------------
module ssid_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             pop,
  output logic                  full,
  output logic                  empty,
  output logic [WIDTH-1:0]      head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_one = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Pointers differ only in the wrap bit when the FIFO is full.
  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_one;
      if (w_pop)  r_rptr <= r_rptr + c_one;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/ssid_event_feeder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ssid_event_feeder : buffers SSIDs, sequences clear/stream/read per event (rev 1.0)
// -----------------------------------------------------------------------------
module ssid_event_feeder
  import ssid_event_feeder_pkg::*;
#(
  parameter int FIFODEPTH   = 16,
  parameter int CLEARCYCLES = 1
) (
  input  wire logic           clock,
  input  wire logic           reset,
  ssid_event_feeder_if.slave  bus
);

  localparam int CW = (CLEARCYCLES < 1) ? 1 : $clog2(CLEARCYCLES + 1);
  localparam logic [CW-1:0] c_clear_last = CW'(CLEARCYCLES);
  localparam logic [CW-1:0] c_clear_one  = {{(CW-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_clr_cnt;
  logic [15:0]       r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_new;
  logic              w_clear;
  logic              w_read;
  logic              w_done;
  logic [SSIDBITS:0] w_head;

  ssid_sync_fifo #(
    .WIDTH (SSIDBITS + 1),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.inValid),
    .wdata ({bus.inLast, bus.inSSID}),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_new   = 1'b0;
    w_clear = 1'b0;
    w_read  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_next = CLEAR;
      end
      CLEAR: begin
        // Strobe first, then wait for storage to report it is ready again.
        if (r_clr_cnt != c_clear_last) w_clear = 1'b1;
        else if (bus.storageReady)     w_next  = STREAM;
      end
      STREAM: begin
        w_new = !w_empty;
        w_pop = w_new && bus.storageReady;
        if (w_pop && w_head[SSIDBITS]) w_next = READ;
      end
      READ: begin
        w_read = 1'b1;
        if (bus.readReady) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = w_empty ? IDLE : CLEAR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != CLEAR) r_clr_cnt <= '0;
      else if (w_clear)     r_clr_cnt <= r_clr_cnt + c_clear_one;
      if (w_next == CLEAR && r_state != CLEAR) r_count <= '0;
      else if (w_pop)                          r_count <= sat_inc(r_count);
    end
  end

  assign bus.inReady     = !w_full;
  assign bus.newAddress  = w_new;
  assign bus.SSID        = w_new ? w_head[SSIDBITS-1:0] : '0;
  assign bus.clearMemory = w_clear;
  assign bus.readMemory  = w_read;
  assign bus.eventDone   = w_done;
  assign bus.ssidCount   = r_count;

endmodule
`default_nettype wire

// File: doc/ssid_event_feeder.md
Name: ssid_event_feeder

Overview:
- Upstream stage of BlockMemoryStorage; replaces the free-running AddressCounter in the system build.
- Accepts SSIDs from the hit-decoding front end with a valid/ready handshake and buffers them in a FIFO.
- Sequences each event into storage: clear, then stream, then readout trigger.
- Drives clearMemory, readMemory, SSID and newAddress into storage; honours storageReady and readReady.

Parameters:
- SSIDBITS, 16, SSID width; shared value from the common parameter package.
- FIFODEPTH, 16, input FIFO entries; must be a power of 2, at least 2.
- CLEARCYCLES, 1, cycles clearMemory is held high at event start.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- inSSID  in  SSIDBITS  SSID from front end
- inValid  in  1  inSSID valid
- inLast  in  1  marks last SSID of event; qualified by inValid
- inReady  out  1  FIFO can accept (not full)
- storageReady  in  1  storage can take an SSID this cycle
- readReady  in  1  storage readout complete
- SSID  out  SSIDBITS  SSID to storage
- newAddress  out  1  SSID valid to storage; transfer when newAddress && storageReady
- clearMemory  out  1  storage clear strobe
- readMemory  out  1  storage readout request
- eventDone  out  1  one-cycle pulse at end of event readout
- ssidCount  out  16  SSIDs written in current/last event; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high): FIFO empty; state IDLE.
  - Output values: inReady=1, newAddress=0, clearMemory=0, readMemory=0, eventDone=0, ssidCount=0, SSID=0.
  - Reset mid-event aborts immediately; no clear or read is issued.
- FIFO stores {inLast, inSSID}.
  - Write when inValid && inReady.
  - inReady = !full, registered-equivalent, no combinational path from inValid.
  - Simultaneous read and write while full: the write is refused (inReady=0).
  - Simultaneous read and write while empty: the write is accepted and the entry is visible next cycle.
- State machine: IDLE -> CLEAR -> STREAM -> READ -> DONE -> IDLE.
  - IDLE: wait for FIFO non-empty; then go to CLEAR and zero ssidCount.
  - CLEAR: clearMemory=1 for CLEARCYCLES cycles, then wait for storageReady=1, then go to STREAM.
  - STREAM: newAddress=1 with SSID from the FIFO head whenever the FIFO is non-empty.
    - Pop and increment ssidCount only on newAddress && storageReady.
    - SSID is held stable while newAddress=1 and storageReady=0.
    - Popping an entry with inLast=1 goes to READ the next cycle.
    - FIFO empty mid-event: newAddress=0; stay in STREAM.
  - READ: readMemory=1, held until readReady=1 is sampled; readMemory deasserts the following cycle; go to DONE.
  - DONE: eventDone=1 for one cycle; go to IDLE.
    - The FIFO may already hold the next event, which starts in CLEAR next cycle.
- Front-end SSIDs keep filling the FIFO during CLEAR, READ and DONE.
- Latency: an SSID written into an empty FIFO during STREAM appears on newAddress 1 cycle later.
- Throughput: one SSID per cycle when storageReady is held high.
- Event of one SSID with inLast: CLEAR, 1 write, READ. Zero-length events are not supported; inLast always accompanies a real SSID.
- Pointer arithmetic: log2(FIFODEPTH)+1 bit pointers with wrap bit; full and empty are derived from the pointer MSB comparison.

Decomposition:
- Shared package/header holds SSIDBITS and the state encoding constants (IDLE, CLEAR, STREAM, READ, DONE; 3 bits).
- One sub-module ssid_sync_fifo: parameterised WIDTH/DEPTH synchronous FIFO with push/pop/full/empty/head data.
  - Reused later for the readout side.
- The sequencer FSM and counters stay in ssid_event_feeder.

Test Plan:
- Reset mid-STREAM after 3 of 5 SSIDs pushed -> next cycle all outputs at reset values, inReady=1, no readMemory issued.
- Single event: push SSIDs 0x0011, 0x0022, 0x0033 (last), storageReady=1 ->
  - clearMemory pulses 1 cycle;
  - newAddress high 3 consecutive cycles carrying 0x0011, 0x0022, 0x0033;
  - readMemory high until readReady;
  - eventDone pulse; ssidCount=3.
- Backpressure: toggle storageReady 1,0,0,1 during STREAM -> SSID held stable while stalled; each SSID transferred exactly once; order preserved.
- FIFO full: storageReady=0 in CLEAR, push 17 SSIDs with FIFODEPTH=16 -> inReady=0 after 16 accepted; the 17th is accepted only after the first pop.
- Back-to-back events: 2 events of 4 SSIDs each queued in the FIFO -> second CLEAR starts the cycle after eventDone; ssidCount resets to 0 then reaches 4.
- Wrap-around: stream 40 SSIDs through a 16-deep FIFO with random storageReady -> output sequence equals input sequence; no loss or duplication.
